// File: rtl/shot_sequencer.sv
// -----------------------------------------------------------------------------
// shot_sequencer
//
// Multi-shot experiment sequencer for the DSP processor array. An accepted
// start latches the run configuration and then repeats shots. A shot is one
// START cycle, followed by RUN cycles until every participating core reports
// done, followed by an optional rest gap. The cores are held in reset between
// shots. An experiment can be aborted, and each shot can be bounded by a
// timeout.
//
// Ports
//   clk          DSP clock; all logic on the rising edge
//   reset        asynchronous, active-low; clears all state
//   stb_start    one-cycle pulse; starts an experiment when idle
//   stb_abort    one-cycle pulse; ends the running experiment
//   nshot        shots to run (0 is treated as 1); sampled on accepted start
//   gap          rest cycles between shots; sampled on accepted start
//   timeout      maximum RUN cycles per shot (0 disables); sampled on start
//   procmask     1 = core participates; sampled on accepted start
//   procdone     per-core done level
//   procreset    per-core reset, active-high, registered
//   busy         high in every state except IDLE
//   stb_shotend  one-cycle pulse per completed shot
//   lastshotdone one-cycle pulse in the DONE cycle
//   shotcnt      completed shots in the current or last experiment
//   timeout_err  sticky shot-timeout flag, cleared on the next accepted start
//   state_mon    state encoding IDLE=0 START=1 RUN=2 GAP=3 DONE=4
// -----------------------------------------------------------------------------
module shot_sequencer #(
   parameter int NPROC    = 4,
   parameter int GAPWIDTH = 24
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stb_start,
   input  logic                stb_abort,
   input  logic [31:0]         nshot,
   input  logic [GAPWIDTH-1:0] gap,
   input  logic [31:0]         timeout,
   input  logic [NPROC-1:0]    procmask,
   input  logic [NPROC-1:0]    procdone,
   output logic [NPROC-1:0]    procreset,
   output logic                busy,
   output logic                stb_shotend,
   output logic                lastshotdone,
   output logic [31:0]         shotcnt,
   output logic                timeout_err,
   output logic [2:0]          state_mon
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_RUN   = 3'd2,
      S_GAP   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              state_q, state_d;

   logic [31:0]         nshot_q, nshot_d;
   logic [GAPWIDTH-1:0] gap_q, gap_d;
   logic [31:0]         timeout_q, timeout_d;
   logic [NPROC-1:0]    mask_q, mask_d;
   logic [31:0]         timer_q, timer_d;
   logic [GAPWIDTH-1:0] gapcnt_q, gapcnt_d;
   logic [31:0]         shotcnt_q, shotcnt_d;
   logic                terr_q, terr_d;
   logic                shotend_q, shotend_d;
   logic [NPROC-1:0]    procreset_q, procreset_d;

   logic                start_acc;
   logic                abort_ok;
   logic                complete;
   logic                last_shot;
   logic                timed_out;
   logic                gap_end;

   // Run timer stops at all-ones so a disabled timeout never wraps it.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // ---------------------------------------------------------------------------
   // Event decode
   // ---------------------------------------------------------------------------
   assign start_acc = (state_q == S_IDLE) && stb_start;
   assign abort_ok  = stb_abort &&
                      ((state_q == S_START) || (state_q == S_RUN) || (state_q == S_GAP));
   // Timer 0 is the first RUN cycle; done levels are ignored there because
   // they may still be left over from the previous shot.
   assign complete  = (state_q == S_RUN) && (timer_q != 32'd0) &&
                      (&(procdone | ~mask_q));
   assign last_shot = (shotcnt_q + 32'd1) == nshot_q;
   // Firing on timer T-1 makes the shot last exactly T RUN cycles.
   assign timed_out = (state_q == S_RUN) && (timeout_q != 32'd0) &&
                      (timer_q == timeout_q - 32'd1);
   assign gap_end   = (gapcnt_q == gap_q - GAPWIDTH'(1));

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // ---------------------------------------------------------------------------
   // Next-state logic (completion > abort > timeout)
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (stb_start) state_d = S_START;
         S_START: state_d = abort_ok ? S_DONE : S_RUN;
         S_RUN: begin
            if (complete) begin
               if (last_shot || abort_ok) state_d = S_DONE;
               else if (gap_q == '0)      state_d = S_START;
               else                       state_d = S_GAP;
            end else if (abort_ok || timed_out) begin
               state_d = S_DONE;
            end
         end
         S_GAP: begin
            if (abort_ok)     state_d = S_DONE;
            else if (gap_end) state_d = S_START;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output and datapath next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      nshot_d     = nshot_q;
      gap_d       = gap_q;
      timeout_d   = timeout_q;
      mask_d      = mask_q;
      shotcnt_d   = shotcnt_q;
      terr_d      = terr_q;
      timer_d     = (state_q == S_RUN) ? sat_inc32(timer_q) : 32'd0;
      gapcnt_d    = (state_q == S_GAP) ? gapcnt_q + GAPWIDTH'(1) : '0;
      shotend_d   = complete;
      // Registered from the next state so release lines up with RUN entry.
      procreset_d = (state_d == S_RUN) ? ~mask_q : '1;

      if (start_acc) begin
         nshot_d   = (nshot == 32'd0) ? 32'd1 : nshot;
         gap_d     = gap;
         timeout_d = timeout;
         mask_d    = procmask;
         shotcnt_d = 32'd0;
         terr_d    = 1'b0;
      end

      if (complete) shotcnt_d = shotcnt_q + 32'd1;
      else if (timed_out && !abort_ok) terr_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         nshot_q     <= '0;
         gap_q       <= '0;
         timeout_q   <= '0;
         mask_q      <= '0;
         timer_q     <= '0;
         gapcnt_q    <= '0;
         shotcnt_q   <= '0;
         terr_q      <= 1'b0;
         shotend_q   <= 1'b0;
         procreset_q <= '1;
      end else begin
         nshot_q     <= nshot_d;
         gap_q       <= gap_d;
         timeout_q   <= timeout_d;
         mask_q      <= mask_d;
         timer_q     <= timer_d;
         gapcnt_q    <= gapcnt_d;
         shotcnt_q   <= shotcnt_d;
         terr_q      <= terr_d;
         shotend_q   <= shotend_d;
         procreset_q <= procreset_d;
      end
   end

   assign procreset    = procreset_q;
   assign busy         = (state_q != S_IDLE);
   assign stb_shotend  = shotend_q;
   assign lastshotdone = (state_q == S_DONE);
   assign shotcnt      = shotcnt_q;
   assign timeout_err  = terr_q;
   assign state_mon    = state_q;

endmodule

// File: tb/tb_shot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shot_sequencer
//
// Directed bench for shot_sequencer. Inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point. A small core model raises
// done 10 cycles after its reset is released; some tests drive done by hand.
// -----------------------------------------------------------------------------
module tb_shot_sequencer;
   localparam int NPROC    = 4;
   localparam int GAPWIDTH = 24;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                stb_start = 1'b0;
   logic                stb_abort = 1'b0;
   logic [31:0]         nshot = '0;
   logic [GAPWIDTH-1:0] gap = '0;
   logic [31:0]         timeout = '0;
   logic [NPROC-1:0]    procmask = '0;
   logic [NPROC-1:0]    procdone;
   logic [NPROC-1:0]    procreset;
   logic                busy;
   logic                stb_shotend;
   logic                lastshotdone;
   logic [31:0]         shotcnt;
   logic                timeout_err;
   logic [2:0]          state_mon;

   logic                use_model = 1'b0;
   logic [NPROC-1:0]    model_en  = '0;
   logic [NPROC-1:0]    man_done  = '0;
   logic [NPROC-1:0]    model_done;
   logic [7:0]          mcnt [NPROC];
   int                  cyc = 0;
   int                  checks = 0;
   int                  errors = 0;

   shot_sequencer #(.NPROC(NPROC), .GAPWIDTH(GAPWIDTH)) dut (
      .clk(clk), .reset(reset), .stb_start(stb_start), .stb_abort(stb_abort),
      .nshot(nshot), .gap(gap), .timeout(timeout), .procmask(procmask),
      .procdone(procdone), .procreset(procreset), .busy(busy),
      .stb_shotend(stb_shotend), .lastshotdone(lastshotdone),
      .shotcnt(shotcnt), .timeout_err(timeout_err), .state_mon(state_mon)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < NPROC; i++) begin
         if (procreset[i])          mcnt[i] <= 8'd0;
         else if (mcnt[i] != 8'hFF) mcnt[i] <= mcnt[i] + 8'd1;
      end
   end

   always_comb begin
      model_done = '0;
      for (int i = 0; i < NPROC; i++)
         model_done[i] = model_en[i] && !procreset[i] && (mcnt[i] >= 8'd10);
   end

   assign procdone = use_model ? model_done : man_done;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulses stb_start for one cycle; returns in the START cycle (cycle 1).
   task automatic start_exp(input logic [31:0] n, input logic [GAPWIDTH-1:0] g,
                            input logic [31:0] t, input logic [NPROC-1:0] m);
      nshot = n; gap = g; timeout = t; procmask = m;
      stb_start = 1'b1;
      tick();
      stb_start = 1'b0;
   endtask

   task automatic test_reset();
      tick(); tick();
      checks++; if (procreset !== 4'hF) begin errors++; $display("FAIL rst_procreset got %h expected f", procreset); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b expected 0", busy); end
      checks++; if (state_mon !== 3'd0) begin errors++; $display("FAIL rst_state got %0d expected 0", state_mon); end
      checks++; if (shotcnt !== 32'd0) begin errors++; $display("FAIL rst_shotcnt got %0d expected 0", shotcnt); end
      checks++; if ({stb_shotend, lastshotdone, timeout_err} !== 3'b000) begin errors++; $display("FAIL rst_pulses got %b expected 000", {stb_shotend, lastshotdone, timeout_err}); end
      reset = 1'b1;
      tick();
      checks++; if (state_mon !== 3'd0) begin errors++; $display("FAIL rst_idle_after got %0d expected 0", state_mon); end
   endtask

   task automatic test_three_shots();
      int c0, ns, nlast;
      int t[3];
      ns = 0; nlast = 0;
      use_model = 1'b1; model_en = 4'hF;
      start_exp(32'd3, 24'd5, 32'd0, 4'hF);
      c0 = cyc;
      checks++; if (procreset !== 4'hF || state_mon !== 3'd1) begin errors++; $display("FAIL ts_start got pr=%h st=%0d expected pr=f st=1", procreset, state_mon); end
      tick();
      checks++; if (procreset !== 4'h0 || state_mon !== 3'd2) begin errors++; $display("FAIL ts_run got pr=%h st=%0d expected pr=0 st=2", procreset, state_mon); end
      for (int n = 0; n < 200; n++) begin
         tick();
         if (stb_shotend) begin if (ns < 3) t[ns] = cyc - c0; ns++; end
         if (lastshotdone) nlast++;
         if (state_mon == 3'd0) break;
      end
      checks++; if (ns !== 3) begin errors++; $display("FAIL ts_nshotend got %0d expected 3", ns); end
      checks++; if (t[0] !== 12) begin errors++; $display("FAIL ts_first_end got %0d expected 12", t[0]); end
      checks++; if (t[1] - t[0] !== 17 || t[2] - t[1] !== 17) begin errors++; $display("FAIL ts_period got %0d,%0d expected 17,17", t[1]-t[0], t[2]-t[1]); end
      checks++; if (shotcnt !== 32'd3) begin errors++; $display("FAIL ts_shotcnt got %0d expected 3", shotcnt); end
      checks++; if (nlast !== 1) begin errors++; $display("FAIL ts_lastshot got %0d expected 1", nlast); end
      checks++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ts_end got terr=%b busy=%b expected 0,0", timeout_err, busy); end
   endtask

   task automatic test_zero_nshot_mask();
      int ns;
      logic pr13_low, pr0_low;
      ns = 0; pr13_low = 1'b0; pr0_low = 1'b0;
      use_model = 1'b1; model_en = 4'b0101;
      start_exp(32'd0, 24'd3, 32'd0, 4'b0101);
      for (int n = 0; n < 100; n++) begin
         tick();
         if (stb_shotend) ns++;
         if (!procreset[1] || !procreset[3]) pr13_low = 1'b1;
         if (!procreset[0]) pr0_low = 1'b1;
         if (state_mon == 3'd0) break;
      end
      checks++; if (ns !== 1 || shotcnt !== 32'd1) begin errors++; $display("FAIL zn_shots got %0d/%0d expected 1/1", ns, shotcnt); end
      checks++; if (pr13_low !== 1'b0) begin errors++; $display("FAIL zn_masked_reset got low=%b expected 0", pr13_low); end
      checks++; if (pr0_low !== 1'b1) begin errors++; $display("FAIL zn_active_reset got low=%b expected 1", pr0_low); end
   endtask

   task automatic test_timeout_shot2();
      int ns, run2;
      ns = 0; run2 = 0;
      use_model = 1'b1; model_en = 4'hF;
      start_exp(32'd4, 24'd2, 32'd20, 4'hF);
      for (int n = 0; n < 300; n++) begin
         tick();
         if (stb_shotend) begin ns++; model_en = 4'b0111; end
         if (ns >= 1 && state_mon == 3'd2) run2++;
         if (state_mon == 3'd0) break;
      end
      checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err got %b expected 1", timeout_err); end
      checks++; if (shotcnt !== 32'd1 || ns !== 1) begin errors++; $display("FAIL to_shotcnt got %0d/%0d expected 1/1", shotcnt, ns); end
      checks++; if (run2 !== 20) begin errors++; $display("FAIL to_runcycles got %0d expected 20", run2); end
      model_en = 4'hF;
      start_exp(32'd1, 24'd0, 32'd0, 4'hF);
      checks++; if (timeout_err !== 1'b0 || shotcnt !== 32'd0) begin errors++; $display("FAIL to_clear got terr=%b cnt=%0d expected 0,0", timeout_err, shotcnt); end
      for (int n = 0; n < 100; n++) begin
         tick();
         if (state_mon == 3'd0) break;
      end
      checks++; if (shotcnt !== 32'd1 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_rerun got cnt=%0d terr=%b expected 1,0", shotcnt, timeout_err); end
   endtask

   task automatic test_abort_gap();
      int ns;
      ns = 0;
      use_model = 1'b1; model_en = 4'hF;
      start_exp(32'd10, 24'd100, 32'd0, 4'hF);
      for (int n = 0; n < 400 && ns < 2; n++) begin
         tick();
         if (stb_shotend) ns++;
      end
      repeat (10) tick();
      checks++; if (state_mon !== 3'd3 || ns !== 2) begin errors++; $display("FAIL ab_ingap got st=%0d ns=%0d expected 3,2", state_mon, ns); end
      stb_abort = 1'b1;
      tick();
      stb_abort = 1'b0;
      checks++; if (state_mon !== 3'd4 || lastshotdone !== 1'b1 || shotcnt !== 32'd2) begin errors++; $display("FAIL ab_done got st=%0d last=%b cnt=%0d expected 4,1,2", state_mon, lastshotdone, shotcnt); end
      tick(); tick(); tick();
      checks++; if (state_mon !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL ab_nostart got st=%0d busy=%b expected 0,0", state_mon, busy); end
   endtask

   task automatic test_simultaneous();
      int runc;
      runc = 0;
      use_model = 1'b0; man_done = '0;
      // completion together with abort
      start_exp(32'd5, 24'd0, 32'd0, 4'hF);
      tick(); tick();
      man_done = 4'hF; stb_abort = 1'b1;
      tick();
      man_done = '0; stb_abort = 1'b0;
      checks++; if (stb_shotend !== 1'b1 || shotcnt !== 32'd1 || state_mon !== 3'd4) begin errors++; $display("FAIL sim_abort got end=%b cnt=%0d st=%0d expected 1,1,4", stb_shotend, shotcnt, state_mon); end
      tick();
      // completion on the timeout cycle (T=5 -> fifth RUN cycle is cycle 6)
      start_exp(32'd3, 24'd0, 32'd5, 4'hF);
      repeat (5) tick();
      man_done = 4'hF;
      tick();
      man_done = '0;
      checks++; if (stb_shotend !== 1'b1 || shotcnt !== 32'd1 || timeout_err !== 1'b0 || state_mon !== 3'd1) begin errors++; $display("FAIL sim_timeout got end=%b cnt=%0d terr=%b st=%0d expected 1,1,0,1", stb_shotend, shotcnt, timeout_err, state_mon); end
      // start held during RUN with different config must be ignored
      tick();
      stb_start = 1'b1; nshot = 32'd1; gap = 24'd50;
      tick();
      man_done = 4'hF;
      tick();
      man_done = '0;
      checks++; if (shotcnt !== 32'd2 || state_mon !== 3'd1) begin errors++; $display("FAIL sim_heldstart got cnt=%0d st=%0d expected 2,1", shotcnt, state_mon); end
      stb_start = 1'b0;
      // third shot runs into the timeout alone
      for (int n = 0; n < 50; n++) begin
         tick();
         if (state_mon == 3'd2) runc++;
         if (state_mon == 3'd4) break;
      end
      checks++; if (runc !== 5 || timeout_err !== 1'b1 || shotcnt !== 32'd2) begin errors++; $display("FAIL sim_toonly got run=%0d terr=%b cnt=%0d expected 5,1,2", runc, timeout_err, shotcnt); end
      // start arriving in the DONE cycle is ignored
      stb_start = 1'b1;
      tick();
      stb_start = 1'b0;
      tick();
      checks++; if (state_mon !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL sim_donestart got st=%0d busy=%b expected 0,0", state_mon, busy); end
   endtask

   task automatic test_zero_mask();
      use_model = 1'b0; man_done = '0;
      start_exp(32'd1, 24'd0, 32'd0, 4'h0);
      tick();
      checks++; if (procreset !== 4'hF || state_mon !== 3'd2) begin errors++; $display("FAIL zm_run got pr=%h st=%0d expected f,2", procreset, state_mon); end
      tick();
      checks++; if (stb_shotend !== 1'b0) begin errors++; $display("FAIL zm_blank got %b expected 0", stb_shotend); end
      tick();
      checks++; if (stb_shotend !== 1'b1 || state_mon !== 3'd4) begin errors++; $display("FAIL zm_end got end=%b st=%0d expected 1,4", stb_shotend, state_mon); end
      tick();
   endtask

   task automatic test_midrun_reset_stale();
      use_model = 1'b0; man_done = 4'hF;
      start_exp(32'd3, 24'd0, 32'd0, 4'hF);
      tick();
      checks++; if (procreset !== 4'h0) begin errors++; $display("FAIL st_release got %h expected 0", procreset); end
      tick();
      checks++; if (stb_shotend !== 1'b0 || state_mon !== 3'd2) begin errors++; $display("FAIL st_stale got end=%b st=%0d expected 0,2", stb_shotend, state_mon); end
      tick();
      checks++; if (stb_shotend !== 1'b1 || shotcnt !== 32'd1 || state_mon !== 3'd1) begin errors++; $display("FAIL st_second got end=%b cnt=%0d st=%0d expected 1,1,1", stb_shotend, shotcnt, state_mon); end
      man_done = '0;
      tick(); tick();
      reset = 1'b0;
      #1;
      checks++; if (procreset !== 4'hF || busy !== 1'b0 || state_mon !== 3'd0) begin errors++; $display("FAIL mr_state got pr=%h busy=%b st=%0d expected f,0,0", procreset, busy, state_mon); end
      checks++; if (shotcnt !== 32'd0 || {stb_shotend, lastshotdone, timeout_err} !== 3'b000) begin errors++; $display("FAIL mr_outputs got cnt=%0d flags=%b expected 0,000", shotcnt, {stb_shotend, lastshotdone, timeout_err}); end
      @(negedge clk);
      reset = 1'b1;
      tick(); tick();
      checks++; if (state_mon !== 3'd0 || lastshotdone !== 1'b0) begin errors++; $display("FAIL mr_after got st=%0d last=%b expected 0,0", state_mon, lastshotdone); end
   endtask

   initial begin
      test_reset();
      test_three_shots();
      test_zero_nshot_mask();
      test_timeout_shot2();
      test_abort_gap();
      test_simultaneous();
      test_zero_mask();
      test_midrun_reset_stale();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shot_sequencer.md
# shot_sequencer

Multi-shot experiment sequencer for the DSP processor array. It takes a start strobe and a shot count, and holds the `proc_core` instances in reset between shots. It waits for every participating processor to report done, then inserts a programmable rest gap before the next shot. It replaces the inline shot state machine in the DSP top level and adds abort, per-shot timeout and processor masking.

## Interface
- `NPROC`, 4, number of processor cores sequenced
- `GAPWIDTH`, 24, width of inter-shot gap counter
- `clk`  in  1  DSP clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `stb_start`  in  1  one-cycle pulse; starts an experiment when IDLE
- `stb_abort`  in  1  one-cycle pulse; ends the experiment after the current cycle
- `nshot`  in  32  shots to run; sampled on accepted `stb_start`; 0 treated as 1
- `gap`  in  GAPWIDTH  rest cycles between shots; sampled with `nshot`
- `timeout`  in  32  maximum RUN cycles per shot; 0 disables; sampled with `nshot`
- `procmask`  in  NPROC  1 = processor participates; sampled with `nshot`
- `procdone`  in  NPROC  per-processor done level from each `proc_core`
- `procreset`  out  NPROC  per-processor reset, active-high, registered
- `busy`  out  1  high in every state except IDLE
- `stb_shotend`  out  1  one-cycle pulse per completed shot
- `lastshotdone`  out  1  one-cycle pulse when the experiment ends
- `shotcnt`  out  32  completed shots in the current or last experiment
- `timeout_err`  out  1  sticky; set by a shot timeout; cleared on the next accepted start
- `state_mon`  out  3  current state encoding: IDLE=0, START=1, RUN=2, GAP=3, DONE=4

## Operation
- **Reset values.** state IDLE, `procreset` all 1, `busy` 0, `stb_shotend` 0, `lastshotdone` 0, `shotcnt` 0, `timeout_err` 0. Latched `nshot`, `gap`, `timeout` and mask are all 0.
- **IDLE.**
  - `procreset` is all 1.
  - `stb_start` moves to START. It latches the config, clears `shotcnt` and `timeout_err`, and sets `nshot_eff = max(nshot,1)`.
- **START.** One cycle; `procreset` is still all 1; next state is RUN.
- **RUN.**
  - `procreset[i] = ~mask[i]`.
  - The run timer counts from 0.
  - Completion condition: `&(procdone | ~mask)`, evaluated from the second RUN cycle onward. The first-cycle blanking masks stale done levels.
  - On completion:
    - pulse `stb_shotend` and increment `shotcnt`.
    - if the new count equals `nshot_eff`, go to DONE.
    - else if `gap` is 0, go to START; otherwise go to GAP.
  - On timeout (`timeout != 0` and the timer reaches `timeout` without completion): set `timeout_err`, do not increment `shotcnt`, go to DONE.
- **GAP.** `procreset` is all 1; stay for exactly `gap` cycles, then go to START.
- **DONE.** One cycle; pulse `lastshotdone`; `procreset` is all 1; next state is IDLE. `shotcnt` holds its value until the next start.
- **Abort.** `stb_abort` in START, RUN or GAP forces DONE on the next cycle. In IDLE or DONE it is ignored.
- **Priority when events coincide in one cycle:** completion > abort > timeout.
  - Completion plus abort: the shot is counted, then DONE.
  - Completion plus timeout: no error.
- **Ignored starts.** `stb_start` while `busy` is ignored, as is a `stb_start` arriving in the DONE cycle.
- **All-zero mask.** Each shot completes on the second RUN cycle.
- **Counter widths.** `shotcnt` cannot wrap: it stops at `nshot_eff`, which is at most 2^32−1. The run timer is 32 bits and saturates at all-ones when timeout is disabled.
- **Asynchronous reset mid-experiment.** Returns to IDLE with reset values immediately, asserting `procreset`. No `lastshotdone` is emitted.

## Timing
- `stb_start` sampled at edge 0 → START from cycle 1 → RUN from cycle 2. `procreset` deasserts for masked-in processors in cycle 2; it is registered from the next state.
- Completion sampled at edge k → `stb_shotend` high in cycle k+1, `shotcnt` updated in cycle k+1, `procreset` all 1 from cycle k+1.
- Shot period = 1 (START) + RUN cycles + `gap`.
- Timeout: the first RUN cycle is timer 0. `timeout=T` → DONE entered after T RUN cycles.
- Last completion at edge k → DONE in cycle k+1 with `lastshotdone` high → IDLE in cycle k+2. `busy` falls in cycle k+2.
- Abort sampled at edge k → DONE in cycle k+1.

## Test plan
- **Three shots with gap.** `nshot=3`, `gap=5`, mask=4'hF; `procdone` rises 10 cycles after each `procreset` release → three `stb_shotend` pulses 17 cycles apart, `shotcnt`=3, one `lastshotdone`, `timeout_err`=0.
- **Zero nshot, partial mask.** `nshot=0`, mask=4'b0101; only `procdone[0]` and `procdone[2]` driven → exactly one shot; `procreset[1]` and `procreset[3]` stay 1 throughout.
- **Timeout on shot 2.** `timeout=20`, `nshot=4`; `procdone[3]` never rises in shot 2 → `timeout_err`=1, `shotcnt`=1, DONE 20 RUN cycles into shot 2. A new start clears `timeout_err`.
- **Abort in GAP.** `nshot=10`, `gap=100`; `stb_abort` during the second gap → DONE next cycle, `shotcnt`=2, no further START.
- **Simultaneous events.** Completion coincides with abort and with a timeout at `timeout=T` → shot counted, `timeout_err`=0. Also: `stb_start` held during RUN → ignored, config unchanged.
- **Mid-run reset, stale done.** Assert `reset` low mid-RUN → `procreset` all 1 immediately and all outputs at reset values. Separately, stale `procdone` high on the first RUN cycle → not taken as completion.
